// File: rtl/elbeth_dmem_responder_pkg.sv
// Shared encodings and address helpers for the ELBETH data-memory responder.
package elbeth_dmem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_X = 2'd3;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_WAIT   = 2'd1,
    DMEM_ACCESS = 2'd2,
    DMEM_RESP   = 2'd3
  } dmem_state_t;

  // Size 3 or a byte offset that is not a multiple of the access size.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: return 1'b0;
      MEM_SIZE_H: return off[0];
      MEM_SIZE_W: return (off != 2'b00);
      default:    return 1'b1;
    endcase
  endfunction

  // Clears the offset bits below the access size.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: return off;
      MEM_SIZE_H: return {off[1], 1'b0};
      default:    return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/elbeth_dmem_sram.sv
// Single-port 32-bit SRAM with per-byte write enables and one-cycle synchronous read.
module elbeth_dmem_sram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/elbeth_dmem_responder.sv
// Data-memory responder: request capture, wait states, lane steering and extension.
// Optional feature macro: ELBETH_DMEM_MISALIGN_CHECK_EN (misaligned / size-3 error reporting).
module elbeth_dmem_responder
  import elbeth_dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_en,
  input  logic        dmem_we,
  input  logic [1:0]  dmem_size,
  input  logic        dmem_sign,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        req_we;
  logic        req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready_q;
  logic        error_q;

  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic        in_bad;

  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        unused_addr_bits;

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      MEM_SIZE_B: return {4{wdata[7:0]}};
      MEM_SIZE_H: return {2{wdata[15:0]}};
      default:    return wdata;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: return 4'b0001 << off;
      MEM_SIZE_H: return 4'b0011 << {off[1], 1'b0};
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic sign, input logic [1:0] off);
    logic [31:0] lane;
    case (size)
      MEM_SIZE_B: begin
        lane = word >> {off, 3'b000};
        return sign ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      end
      MEM_SIZE_H: begin
        lane = word >> {off[1], 4'b0000};
        return sign ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
      end
      default: return word;
    endcase
  endfunction

`ifdef ELBETH_DMEM_MISALIGN_CHECK_EN
  always_comb begin
    in_size = dmem_size;
    in_addr = dmem_addr;
    in_bad  = is_bad(dmem_size, dmem_addr[1:0]);
  end
`else
  // Without checking, size 3 acts as a word and the access truncates to its aligned address.
  always_comb begin
    in_size = (dmem_size == MEM_SIZE_X) ? MEM_SIZE_W : dmem_size;
    in_addr = {dmem_addr[31:2], align_off(in_size, dmem_addr[1:0])};
    in_bad  = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DMEM_IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      req_we    <= 1'b0;
      req_sign  <= 1'b0;
      req_size  <= 2'd0;
      req_addr  <= 32'h0;
      req_wdata <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      case (state)
        DMEM_IDLE: begin
          if (dmem_en) begin
            req_we    <= dmem_we;
            req_sign  <= dmem_sign;
            req_size  <= in_size;
            req_addr  <= in_addr;
            req_wdata <= dmem_wdata;
            if (in_bad) begin
              state   <= DMEM_RESP;
              ready_q <= 1'b1;
              error_q <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state <= DMEM_ACCESS;
            end else begin
              cnt   <= WAIT_INIT;
              state <= DMEM_WAIT;
            end
          end
        end
        DMEM_WAIT: begin
          // A dropped request is a pipeline flush: abandon without touching the RAM.
          if (!dmem_en) begin
            cnt   <= 4'd0;
            state <= DMEM_IDLE;
          end else if (cnt <= 4'd1) begin
            cnt   <= 4'd0;
            state <= DMEM_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DMEM_ACCESS: begin
          state   <= DMEM_RESP;
          ready_q <= 1'b1;
        end
        DMEM_RESP: state <= DMEM_IDLE;
        default:   state <= DMEM_IDLE;
      endcase
    end
  end

  // The strobe is not gated by rst, so a store already in ACCESS still commits on a reset edge.
  assign ram_en    = (state == DMEM_ACCESS);
  assign ram_be    = store_be(req_size, req_addr[1:0]);
  assign ram_wdata = store_data(req_size, req_wdata);
  assign unused_addr_bits = ^req_addr;

  elbeth_dmem_sram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk  (clk),
    .en   (ram_en),
    .we   (req_we),
    .be   (ram_be),
    .addr (req_addr[ADDR_WIDTH+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign dmem_ready = ready_q;
  assign dmem_error = error_q;
  assign dmem_rdata = (ready_q && !error_q && !req_we)
                      ? load_extract(ram_rdata, req_size, req_sign, req_addr[1:0])
                      : 32'h0;

endmodule

// File: tb/tb_elbeth_dmem_responder.sv
// Directed bench for elbeth_dmem_responder: three instances with WAIT_CYCLES 1, 3 and 0.
module tb_elbeth_dmem_responder;

`ifdef ELBETH_DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        c_en    [3];
  logic        c_we    [3];
  logic [1:0]  c_size  [3];
  logic        c_sign  [3];
  logic [31:0] c_addr  [3];
  logic [31:0] c_wdata [3];
  logic [31:0] r_data  [3];
  logic        r_ready [3];
  logic        r_error [3];

  int checks;
  int failures;
  int cyc;

  elbeth_dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .dmem_en(c_en[0]), .dmem_we(c_we[0]), .dmem_size(c_size[0]),
    .dmem_sign(c_sign[0]), .dmem_addr(c_addr[0]), .dmem_wdata(c_wdata[0]),
    .dmem_rdata(r_data[0]), .dmem_ready(r_ready[0]), .dmem_error(r_error[0]));

  elbeth_dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .dmem_en(c_en[1]), .dmem_we(c_we[1]), .dmem_size(c_size[1]),
    .dmem_sign(c_sign[1]), .dmem_addr(c_addr[1]), .dmem_wdata(c_wdata[1]),
    .dmem_rdata(r_data[1]), .dmem_ready(r_ready[1]), .dmem_error(r_error[1]));

  elbeth_dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .dmem_en(c_en[2]), .dmem_we(c_we[2]), .dmem_size(c_size[2]),
    .dmem_sign(c_sign[2]), .dmem_addr(c_addr[2]), .dmem_wdata(c_wdata[2]),
    .dmem_rdata(r_data[2]), .dmem_ready(r_ready[2]), .dmem_error(r_error[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input int d, input string name);
    chk({name, "_ready"}, {31'b0, r_ready[d]}, 32'h0);
    chk({name, "_error"}, {31'b0, r_error[d]}, 32'h0);
    chk({name, "_rdata"}, r_data[d], 32'h0);
  endtask

  // One full handshake; lat is the edge count from the sampling edge to the edge that sees ready.
  task automatic run_req(input int d, input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    c_en[d] = 1'b1; c_we[d] = we; c_size[d] = size; c_sign[d] = sign;
    c_addr[d] = addr; c_wdata[d] = wdata;
    @(posedge clk); #1;
    n = 0;
    while (!r_ready[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    rd  = r_data[d];
    er  = r_error[d];
    lat = r_ready[d] ? n + 1 : -1;
    c_en[d] = 1'b0;
    @(posedge clk); #1;
    chk("ready_single_pulse", {31'b0, r_ready[d]}, 32'h0);
  endtask

  task automatic req_expect(input int d, input logic we, input logic [1:0] size, input logic sign,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input int exp_lat, input string name);
    logic [31:0] rd;
    logic        er;
    int          lat;
    run_req(d, we, size, sign, addr, wdata, rd, er, lat);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_error"}, {31'b0, er}, 32'h0);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, d1, d2;
    logic        er;
    int          lat, c1, c2, n, seen;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_en[i] = 1'b0; c_we[i] = 1'b0; c_size[i] = 2'd0; c_sign[i] = 1'b0;
      c_addr[i] = 32'h0; c_wdata[i] = 32'h0;
    end

    // WAIT_CYCLES=1: aligned latency 3, error latency 1.
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 3});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h13,   32'h12345680, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'h00000080, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b1, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h11,   32'h0,
                    CHK ? 32'h0 : 32'hFFFFBEEF, CHK, CHK ? 1 : 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0, 3});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h14,   32'h11223344, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h16,   32'h1234CAFE, 32'h0,        1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h14,   32'h0,        32'hCAFE3344, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h16,   32'h0,        32'hFFFFCAFE, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h14,   32'h0,        32'h00003344, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h15,   32'h0,        32'h00000033, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,
                    CHK ? 32'h0 : 32'h80ADBEEF, CHK, CHK ? 1 : 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h12,   32'h0,
                    CHK ? 32'h0 : 32'h80ADBEEF, CHK, CHK ? 1 : 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h1010, 32'h0,        32'h80ADBEEF, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h12,   32'h0,        32'hFFFFFFAD, 1'b0, 3});

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_idle_outputs(d, "reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_req(0, tbl[i].we, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_error", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
    end

    // Flush during WAIT (WAIT_CYCLES=3): no ready, no write.
    req_expect(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h55667788, 32'h0, 5, "w3_store");
    @(negedge clk);
    c_en[1] = 1'b1; c_we[1] = 1'b1; c_size[1] = 2'd2; c_addr[1] = 32'h20; c_wdata[1] = 32'hAAAAAAAA;
    @(posedge clk);
    @(negedge clk);
    c_en[1] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (r_ready[1]) seen = 1;
    end
    chk("flush_no_ready", seen, 0);
    req_expect(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h55667788, 5, "flush_mem_unchanged");

    // Reset while the store sits in ACCESS: the write still lands.
    req_expect(1, 1'b1, 2'd2, 1'b0, 32'h24, 32'h11111111, 32'h0, 5, "w3_store24");
    @(negedge clk);
    c_en[1] = 1'b1; c_we[1] = 1'b1; c_size[1] = 2'd2; c_addr[1] = 32'h24; c_wdata[1] = 32'h0BADF00D;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; c_en[1] = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs(1, "rst_access");
    @(negedge clk);
    rst = 1'b0;
    req_expect(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'h0BADF00D, 5, "rst_access_written");

    // Reset while the store is still in WAIT: the write is dropped.
    @(negedge clk);
    c_en[1] = 1'b1; c_we[1] = 1'b1; c_size[1] = 2'd2; c_addr[1] = 32'h24; c_wdata[1] = 32'h22222222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; c_en[1] = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs(1, "rst_wait");
    @(negedge clk);
    rst = 1'b0;
    req_expect(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'h0BADF00D, 5, "rst_wait_not_written");

    // WAIT_CYCLES=0: two loads with dmem_en held, first one through the 0x1000 alias.
    req_expect(2, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0A0B0C0D, 32'h0, 2, "w0_store0");
    req_expect(2, 1'b1, 2'd2, 1'b0, 32'h4, 32'h00000099, 32'h0, 2, "w0_store4");
    @(negedge clk);
    c_en[2] = 1'b1; c_we[2] = 1'b0; c_size[2] = 2'd2; c_sign[2] = 1'b0; c_addr[2] = 32'h1000;
    @(posedge clk); #1;
    n = 0;
    while (!r_ready[2] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    c1 = cyc; d1 = r_data[2];
    c_addr[2] = 32'h4;
    @(posedge clk); #1;
    n = 0;
    while (!r_ready[2] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    c2 = cyc; d2 = r_data[2];
    c_en[2] = 1'b0;
    chk("b2b_alias_rdata", d1, 32'h0A0B0C0D);
    chk("b2b_second_rdata", d2, 32'h00000099);
    chk("b2b_ready_spacing", c2 - c1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
